nibble_serial_adder: RTL and testbench

Sequential controller that adds two NIBBLES×4-bit operands by streaming them, one nibble per cycle, least significant first, through an external 4-bit ripple-adder slice. It sits directly upstream of that adder slice, supplying its operand nibbles and carry-in. It also sits downstream of it, capturing each nibble sum and the carry-out, chaining the carry across cycles and assembling the wide result. It trades latency for area: one 4-bit adder serves any operand width.

---
 rtl/nibble_serial_adder_if.sv | 45 ++++
 rtl/nibble_serial_adder.sv | 117 +++++++++++
 tb/tb_nibble_serial_adder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// Request, result and adder-slice signals for nibble_serial_adder; master is the controller side.
// The sub port exists only when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_s;
  logic         add_cout;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  modport master (
    input  start, a, b, c_in,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  add_s, add_cout,
    output add_a, add_b, add_cin,
    output busy, done, sum, c_out, overflow
  );

  modport slave (
    output start, a, b, c_in,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output add_s, add_cout,
    input  add_a, add_b, add_cin,
    input  busy, done, sum, c_out, overflow
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Serial W-bit add through an external 4-bit slice, one nibble per cycle LSB first; NIBBLE_SERIAL_ADDER_SUB_EN adds subtract.
// Latency: done pulses NIBBLES+1 cycles after the accepting edge; start is ignored outside IDLE (no queuing).
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input logic                  clock,
  input logic                  resetn,
  nibble_serial_adder_if.master bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  sum_q;
  logic          carry;
  logic          busy_q;
  logic          done_q;
  logic          c_out_q;
  logic          ovf_q;

  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [3:0]    b_eff_nib;
  logic          b_eff_msb;
  logic          init_carry;

  assign a_nib = a_reg[{idx, 2'b00} +: 4];
  assign b_nib = b_reg[{idx, 2'b00} +: 4];

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic sub_reg;
  // Subtract is A + ~B + 1; overflow must see the sign of the inverted operand.
  assign b_eff_nib  = sub_reg ? ~b_nib : b_nib;
  assign b_eff_msb  = b_reg[W-1] ^ sub_reg;
  assign init_carry = bus.sub ? 1'b1 : bus.c_in;
`else
  assign b_eff_nib  = b_nib;
  assign b_eff_msb  = b_reg[W-1];
  assign init_carry = bus.c_in;
`endif

  assign bus.add_a    = (state == RUN) ? a_nib     : 4'd0;
  assign bus.add_b    = (state == RUN) ? b_eff_nib : 4'd0;
  assign bus.add_cin  = (state == RUN) ? carry     : 1'b0;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      idx     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_q   <= '0;
      carry   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      sub_reg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_reg   <= bus.a;
            b_reg   <= bus.b;
            carry   <= init_carry;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            sub_reg <= bus.sub;
`endif
            idx     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q[{idx, 2'b00} +: 4] <= bus.add_s;
          carry <= bus.add_cout;
          if (idx == LAST) begin
            // Last nibble: the slice outputs are the final carry and sign bit.
            c_out_q <= bus.add_cout;
            ovf_q   <= (a_reg[W-1] == b_eff_msb) && (bus.add_s[3] != a_reg[W-1]);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (NIBBLES=4) with a behavioural 4-bit slice and an arithmetic reference model.
module tb_nibble_serial_adder;
  localparam int NIBBLES = 4;
  localparam int W = 16;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  nibble_serial_adder_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // External combinational adder slice
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'd0, bus.add_cin};

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference: returns {overflow, c_out, sum}
  function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sb);
    logic [15:0] be;
    logic        ci;
    logic [16:0] r;
    logic        ov;
    be = sb ? ~b : b;
    ci = sb ? 1'b1 : cin;
    r  = {1'b0, a} + {1'b0, be} + {16'd0, ci};
    ov = (a[15] == be[15]) && (r[15] != a[15]);
    return {ov, r};
  endfunction

  // Carry entering nibble i, from the sum of the low 4*i bits
  function automatic logic [3:0] ref_carries(input logic [15:0] a, input logic [15:0] b,
                                             input logic cin, input logic sb);
    logic [15:0] be;
    logic        ci;
    logic [16:0] m;
    logic [16:0] t;
    logic [3:0]  cs;
    be = sb ? ~b : b;
    ci = sb ? 1'b1 : cin;
    cs = 4'd0;
    cs[0] = ci;
    for (int i = 1; i < 4; i++) begin
      m = (17'd1 << (4 * i)) - 17'd1;
      t = ({1'b0, a} & m) + ({1'b0, be} & m) + {16'd0, ci};
      cs[i] = t[4 * i];
    end
    return cs;
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        output logic [15:0] s, output logic co, output logic ov,
                        output int lat, output int nbusy,
                        output logic [15:0] aseq, output logic [3:0] cseq,
                        output logic done_after);
    @(negedge clock);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.c_in = cin;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c_in = 1'b0;
    lat = 0;
    nbusy = 0;
    aseq = '0;
    cseq = '0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.busy) begin
        if (nbusy < 4) begin
          aseq[4 * nbusy +: 4] = bus.add_a;
          cseq[nbusy] = bus.add_cin;
        end
        nbusy++;
      end
      if (bus.done) begin
        lat = c;
        break;
      end
      @(posedge clock); #1;
    end
    s  = bus.sum;
    co = bus.c_out;
    ov = bus.overflow;
    @(posedge clock); #1;
    done_after = bus.done;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic [3:0]  cseq;
  } vec_t;

  vec_t tbl[6];

  logic [15:0] s;
  logic        co, ov, da;
  int          lat, nb;
  logic [15:0] aseq;
  logic [3:0]  cseq;
  logic [17:0] r;
  logic        sb_r;
  int          cyc;

  initial begin
    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 4'b0000};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110};
    tbl[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 4'b1111};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000};
    tbl[4] = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 4'b0000};
    tbl[5] = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 1'b0, 4'b1111};

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c_in = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    bus.sub = 1'b0;
`endif
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    check("rst_sum", {16'd0, bus.sum}, 0);
    check("rst_cout", {31'd0, bus.c_out}, 0);
    check("rst_ovf", {31'd0, bus.overflow}, 0);
    check("rst_add", {23'd0, bus.add_a, bus.add_b, bus.add_cin}, 0);
    @(negedge clock);
    resetn = 1'b1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, s, co, ov, lat, nb, aseq, cseq, da);
      check($sformatf("t%0d_sum", i), {16'd0, s}, {16'd0, tbl[i].s});
      check($sformatf("t%0d_cout", i), {31'd0, co}, {31'd0, tbl[i].co});
      check($sformatf("t%0d_ovf", i), {31'd0, ov}, {31'd0, tbl[i].ov});
      check($sformatf("t%0d_latency", i), lat, NIBBLES + 1);
      check($sformatf("t%0d_busy_cycles", i), nb, NIBBLES);
      check($sformatf("t%0d_add_a_seq", i), {16'd0, aseq}, {16'd0, tbl[i].a});
      check($sformatf("t%0d_add_cin_seq", i), {28'd0, cseq}, {28'd0, tbl[i].cseq});
      check($sformatf("t%0d_done_pulse", i), {31'd0, da}, 0);
    end

    // Start during RUN and DONE is ignored
    @(negedge clock);
    bus.start = 1'b1;
    bus.a = 16'h0001;
    bus.b = 16'h0001;
    @(posedge clock); #1;
    bus.start = 1'b0;
    cyc = 1;
    @(negedge clock);
    bus.start = 1'b1;
    bus.a = 16'hAAAA;
    bus.b = 16'hAAAA;
    @(posedge clock); #1;
    bus.start = 1'b0;
    cyc++;
    while (!bus.done && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("ign_latency", cyc, NIBBLES + 1);
    check("ign_run_sum", {16'd0, bus.sum}, 32'h0002);
    @(negedge clock);
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    check("ign_done_busy", {31'd0, bus.busy}, 0);
    check("ign_done_sum", {16'd0, bus.sum}, 32'h0002);
    run_op(16'h0005, 16'h0006, 1'b0, s, co, ov, lat, nb, aseq, cseq, da);
    check("after_done_sum", {16'd0, s}, 32'h000B);
    check("after_done_latency", lat, NIBBLES + 1);

    // Asynchronous reset mid-operation
    @(negedge clock);
    bus.start = 1'b1;
    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) begin
      @(posedge clock); #1;
    end
    check("mid_partial_sum", {16'd0, bus.sum}, 32'h00FE);
    check("mid_busy", {31'd0, bus.busy}, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 0);
    check("arst_sum", {16'd0, bus.sum}, 0);
    check("arst_flags", {29'd0, bus.done, bus.c_out, bus.overflow}, 0);
    check("arst_add", {23'd0, bus.add_a, bus.add_b, bus.add_cin}, 0);
    @(negedge clock);
    resetn = 1'b1;
    run_op(16'h0003, 16'h0004, 1'b0, s, co, ov, lat, nb, aseq, cseq, da);
    check("post_rst_sum", {16'd0, s}, 32'h0007);
    check("post_rst_latency", lat, NIBBLES + 1);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    bus.sub = 1'b1;
    run_op(16'h0005, 16'h0007, 1'b0, s, co, ov, lat, nb, aseq, cseq, da);
    check("sub1_sum", {16'd0, s}, 32'hFFFE);
    check("sub1_flags", {30'd0, co, ov}, 32'd0);
    run_op(16'h8000, 16'h0001, 1'b0, s, co, ov, lat, nb, aseq, cseq, da);
    check("sub2_sum", {16'd0, s}, 32'h7FFF);
    check("sub2_flags", {30'd0, co, ov}, 32'd3);
    bus.sub = 1'b0;
`endif

    // Random operations against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      logic [15:0] ra, rb;
      logic        rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      sb_r = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      sb_r = 1'($urandom_range(0, 1));
      bus.sub = sb_r;
`endif
      r = ref_add(ra, rb, rc, sb_r);
      run_op(ra, rb, rc, s, co, ov, lat, nb, aseq, cseq, da);
      check($sformatf("r%0d_result", i), {14'd0, ov, co, s}, {14'd0, r});
      check($sformatf("r%0d_latency", i), lat, NIBBLES + 1);
      check($sformatf("r%0d_add_cin_seq", i), {28'd0, cseq}, {28'd0, ref_carries(ra, rb, rc, sb_r)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
